// File: rtl/uart_pkg.sv
// Shared types and bit-rate constants for the UART link partner.
package uart_pkg;

    localparam int DivWidth = 13;

    localparam logic [1:0] RateDefault = 2'd0;
    localparam logic [1:0] Rate2604    = 2'd1;
    localparam logic [1:0] Rate1302    = 2'd2;
    localparam logic [1:0] Rate434     = 2'd3;

    localparam logic [DivWidth-1:0] Div5207 = 13'd5207;
    localparam logic [DivWidth-1:0] Div2604 = 13'd2604;
    localparam logic [DivWidth-1:0] Div1302 = 13'd1302;
    localparam logic [DivWidth-1:0] Div434  = 13'd434;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    function automatic logic [DivWidth-1:0] rateDiv(input logic [1:0] rateSel,
                                                    input logic [DivWidth-1:0] defaultDiv);
        logic [DivWidth-1:0] div;
        case (rateSel)
            Rate2604: div = Div2604;
            Rate1302: div = Div1302;
            Rate434:  div = Div434;
            default:  div = defaultDiv;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/uart_link_partner_if.sv
// Parallel byte-stream side of the link partner: TX and RX valid/ready plus RX status pulses.
interface uart_link_partner_if;

    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_err;
    logic       rx_overrun;

    modport master (
        output tx_byte, tx_valid, rx_ready,
        input  tx_ready, rx_byte, rx_valid, rx_err, rx_overrun
    );

    modport slave (
        input  tx_byte, tx_valid, rx_ready,
        output tx_ready, rx_byte, rx_valid, rx_err, rx_overrun
    );

endinterface

// File: rtl/uart_link_rxbuf.sv
// Two-entry receive FIFO; head reads as zero when empty.
module uart_link_rxbuf (
    input  logic       clk,
    input  logic       nReset,
    input  logic       push,
    input  logic [7:0] pushData,
    input  logic       pop,
    output logic [7:0] headData,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);
    import uart_pkg::*;

    logic [7:0] mem [2];
    logic       wrPtr;
    logic       rdPtr;
    logic       doPush;
    logic       doPop;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headData = empty ? 8'h00 : mem[rdPtr];

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            mem[0] <= 8'h00;
            mem[1] <= 8'h00;
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= ~wrPtr;
            end
            if (doPop) begin
                rdPtr <= ~rdPtr;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_link_partner.sv
// 8N1 link partner with RTS/CTS: parallel bytes to serial_out, serial_in to a buffered byte stream.
//  state     | meaning
//  TX_IDLE   | line high, accepting a byte when peer not full
//  TX_START  | start bit (low) for one bit period
//  TX_DATA   | 8 data bits, LSB first
//  TX_STOP   | stop bit (high) for one bit period
//  RX_IDLE   | waiting for falling edge on synchronized line
//  RX_START  | half-period wait, then confirm start bit
//  RX_DATA   | sampling 8 data bits at bit centres
//  RX_STOP   | sampling stop bit; push, overrun or framing error
//  RX_BREAK  | line held low after framing error, wait for high
module uart_link_partner #(
    parameter int DefaultDiv = 5207,
    parameter int RxDepth    = 2
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic [1:0]          rate_sel,
    uart_link_partner_if.slave  bus,
    output logic                serial_out,
    input  logic                serial_in,
    input  logic                peer_rts,
    output logic                cts_out
);
    import uart_pkg::*;

    logic [DivWidth-1:0] curDiv;
    assign curDiv = rateDiv(rate_sel, DivWidth'(DefaultDiv));

    tx_state_t           txState, txStateNext;
    logic [DivWidth-1:0] txCnt, txCntNext;
    logic [DivWidth-1:0] txDiv, txDivNext;
    logic [2:0]          txBit, txBitNext;
    logic [7:0]          txShift, txShiftNext;
    logic                serialOutQ, serialOutNext;
    logic                txArmed;
    logic                txReady;
    logic                txFire;

    assign txReady     = txArmed && (txState == TX_IDLE) && !peer_rts;
    assign txFire      = txReady && bus.tx_valid;
    assign bus.tx_ready = txReady;
    assign serial_out  = serialOutQ;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            txState    <= TX_IDLE;
            txCnt      <= '0;
            txDiv      <= '0;
            txBit      <= '0;
            txShift    <= '0;
            serialOutQ <= 1'b1;
            txArmed    <= 1'b0;
        end else begin
            txState    <= txStateNext;
            txCnt      <= txCntNext;
            txDiv      <= txDivNext;
            txBit      <= txBitNext;
            txShift    <= txShiftNext;
            serialOutQ <= serialOutNext;
            txArmed    <= 1'b1;
        end
    end

    // Counters load period-1 and expire at zero, so each level lasts exactly one period.
    always_comb begin
        txStateNext   = txState;
        txCntNext     = txCnt;
        txDivNext     = txDiv;
        txBitNext     = txBit;
        txShiftNext   = txShift;
        serialOutNext = serialOutQ;
        case (txState)
            TX_IDLE: begin
                serialOutNext = 1'b1;
                if (txFire) begin
                    txShiftNext   = bus.tx_byte;
                    txDivNext     = curDiv;
                    txCntNext     = curDiv - 1'b1;
                    serialOutNext = 1'b0;
                    txStateNext   = TX_START;
                end
            end
            TX_START: begin
                if (txCnt == '0) begin
                    txCntNext     = txDiv - 1'b1;
                    txBitNext     = 3'd0;
                    serialOutNext = txShift[0];
                    txStateNext   = TX_DATA;
                end else begin
                    txCntNext = txCnt - 1'b1;
                end
            end
            TX_DATA: begin
                if (txCnt == '0) begin
                    txCntNext = txDiv - 1'b1;
                    if (txBit == 3'd7) begin
                        serialOutNext = 1'b1;
                        txStateNext   = TX_STOP;
                    end else begin
                        txBitNext     = txBit + 3'd1;
                        txShiftNext   = txShift >> 1;
                        serialOutNext = txShift[1];
                    end
                end else begin
                    txCntNext = txCnt - 1'b1;
                end
            end
            TX_STOP: begin
                if (txCnt == '0) begin
                    txStateNext = TX_IDLE;
                end else begin
                    txCntNext = txCnt - 1'b1;
                end
            end
            default: txStateNext = TX_IDLE;
        endcase
    end

    logic                syncA, rxS;
    rx_state_t           rxState, rxStateNext;
    logic [DivWidth-1:0] rxCnt, rxCntNext;
    logic [DivWidth-1:0] rxDiv, rxDivNext;
    logic [2:0]          rxBit, rxBitNext;
    logic [7:0]          rxShift, rxShiftNext;
    logic                rxPush, rxErrSet, rxOvrSet;
    logic                rxErrQ, rxOvrQ, ctsQ;
    logic                rxBusy;
    logic [7:0]          bufHead;
    logic [1:0]          bufCount;
    logic                bufFull, bufEmpty;

    assign rxBusy         = (rxState != RX_IDLE) && (rxState != RX_BREAK);
    assign bus.rx_valid   = !bufEmpty;
    assign bus.rx_byte    = bufHead;
    assign bus.rx_err     = rxErrQ;
    assign bus.rx_overrun = rxOvrQ;
    assign cts_out        = ctsQ;

    uart_link_rxbuf rxBuf (
        .clk      (clk),
        .nReset   (nReset),
        .push     (rxPush),
        .pushData (rxShift),
        .pop      (bus.rx_ready),
        .headData (bufHead),
        .count    (bufCount),
        .full     (bufFull),
        .empty    (bufEmpty)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            syncA   <= 1'b1;
            rxS     <= 1'b1;
            rxState <= RX_IDLE;
            rxCnt   <= '0;
            rxDiv   <= '0;
            rxBit   <= '0;
            rxShift <= '0;
            rxErrQ  <= 1'b0;
            rxOvrQ  <= 1'b0;
            ctsQ    <= 1'b1;
        end else begin
            syncA   <= serial_in;
            rxS     <= syncA;
            rxState <= rxStateNext;
            rxCnt   <= rxCntNext;
            rxDiv   <= rxDivNext;
            rxBit   <= rxBitNext;
            rxShift <= rxShiftNext;
            rxErrQ  <= rxErrSet;
            rxOvrQ  <= rxOvrSet;
            // A frame in flight reserves a slot, so a peer honouring CTS never overruns.
            ctsQ    <= ({1'b0, bufCount} + {2'b00, rxBusy}) < 3'(RxDepth);
        end
    end

    always_comb begin
        rxStateNext = rxState;
        rxCntNext   = rxCnt;
        rxDivNext   = rxDiv;
        rxBitNext   = rxBit;
        rxShiftNext = rxShift;
        rxPush      = 1'b0;
        rxErrSet    = 1'b0;
        rxOvrSet    = 1'b0;
        case (rxState)
            RX_IDLE: begin
                if (!rxS) begin
                    rxDivNext   = curDiv;
                    rxCntNext   = (curDiv >> 1) - 1'b1;
                    rxStateNext = RX_START;
                end
            end
            RX_START: begin
                if (rxCnt == '0) begin
                    if (!rxS) begin
                        rxCntNext   = rxDiv - 1'b1;
                        rxBitNext   = 3'd0;
                        rxStateNext = RX_DATA;
                    end else begin
                        rxStateNext = RX_IDLE;
                    end
                end else begin
                    rxCntNext = rxCnt - 1'b1;
                end
            end
            RX_DATA: begin
                if (rxCnt == '0) begin
                    rxShiftNext = {rxS, rxShift[7:1]};
                    rxCntNext   = rxDiv - 1'b1;
                    if (rxBit == 3'd7) begin
                        rxStateNext = RX_STOP;
                    end else begin
                        rxBitNext = rxBit + 3'd1;
                    end
                end else begin
                    rxCntNext = rxCnt - 1'b1;
                end
            end
            RX_STOP: begin
                if (rxCnt == '0) begin
                    if (rxS) begin
                        rxPush      = !bufFull;
                        rxOvrSet    = bufFull;
                        rxStateNext = RX_IDLE;
                    end else begin
                        rxErrSet    = 1'b1;
                        rxStateNext = RX_BREAK;
                    end
                end else begin
                    rxCntNext = rxCnt - 1'b1;
                end
            end
            RX_BREAK: begin
                if (rxS) begin
                    rxStateNext = RX_IDLE;
                end
            end
            default: rxStateNext = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_link_partner.sv
// Directed bench for uart_link_partner at rate_sel=3 (434 clocks per bit).
module tb_uart_link_partner;

    localparam int D         = 434;
    localparam int FrameClks = 10 * D;

    logic       clk = 1'b0;
    logic       nReset;
    logic [1:0] rateSel;
    logic       serialOut;
    logic       serialIn;
    logic       peerRts;
    logic       ctsOut;

    int checkCnt  = 0;
    int errCnt    = 0;
    int errPulses = 0;
    int ovrPulses = 0;
    int errBase;
    int ovrBase;
    logic probeValid [3];
    logic probeCts [3];
    logic [9:0] txBits;

    uart_link_partner_if bus ();

    uart_link_partner #(
        .DefaultDiv (5207),
        .RxDepth    (2)
    ) dut (
        .clk        (clk),
        .nReset     (nReset),
        .rate_sel   (rateSel),
        .bus        (bus),
        .serial_out (serialOut),
        .serial_in  (serialIn),
        .peer_rts   (peerRts),
        .cts_out    (ctsOut)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (nReset) begin
            if (bus.rx_err)     errPulses++;
            if (bus.rx_overrun) ovrPulses++;
        end
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Drives one frame on serial_in, recording rx_valid/cts_out at a few offsets.
    task automatic sendFrame(input logic [7:0] data, input logic stopBit);
        logic [9:0] frameBits;
        frameBits = {stopBit, data, 1'b0};
        for (int k = 0; k < FrameClks; k++) begin
            serialIn = frameBits[k / D];
            if (k == 10)   begin probeValid[0] = bus.rx_valid; probeCts[0] = ctsOut; end
            if (k == 4110) begin probeValid[1] = bus.rx_valid; probeCts[1] = ctsOut; end
            if (k == 4140) begin probeValid[2] = bus.rx_valid; probeCts[2] = ctsOut; end
            tick();
        end
        serialIn = 1'b1;
    endtask

    task automatic popOne();
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
    endtask

    initial begin
        nReset       = 1'b0;
        rateSel      = 2'd3;
        serialIn     = 1'b1;
        peerRts      = 1'b0;
        bus.tx_byte  = 8'h00;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        checkValue("reset serial_out", serialOut, 1);
        checkValue("reset tx_ready", bus.tx_ready, 0);
        checkValue("reset rx_valid", bus.rx_valid, 0);
        checkValue("reset rx_byte", bus.rx_byte, 8'h00);
        checkValue("reset rx_err", bus.rx_err, 0);
        checkValue("reset rx_overrun", bus.rx_overrun, 0);
        checkValue("reset cts_out", ctsOut, 1);

        nReset = 1'b1;
        checkValue("tx_ready first cycle", bus.tx_ready, 0);
        tick();
        checkValue("tx_ready armed", bus.tx_ready, 1);

        // TX 0xA5, with rate_sel changed mid-frame
        bus.tx_byte  = 8'hA5;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        txBits = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k <= FrameClks; k++) begin
            if (k == 1000) rateSel = 2'd0;
            if (k < FrameClks && ((k % D) == 0 || (k % D) == D - 1))
                checkValue($sformatf("tx A5 bit %0d at %0d", k / D, k), serialOut, txBits[k / D]);
            if (k == FrameClks - 1) checkValue("tx_ready before frame end", bus.tx_ready, 0);
            if (k == FrameClks) begin
                checkValue("tx_ready at 10*D", bus.tx_ready, 1);
                checkValue("tx line idle after frame", serialOut, 1);
            end
            if (k < FrameClks) tick();
        end
        rateSel = 2'd3;

        // peer_rts holds off the frame
        peerRts      = 1'b1;
        bus.tx_byte  = 8'h5A;
        bus.tx_valid = 1'b1;
        idle(20);
        checkValue("tx_ready under rts", bus.tx_ready, 0);
        checkValue("serial_out under rts", serialOut, 1);
        peerRts = 1'b0;
        #1;
        checkValue("tx_ready rts released", bus.tx_ready, 1);
        tick();
        bus.tx_valid = 1'b0;
        checkValue("start bit after rts release", serialOut, 0);
        idle(D);
        checkValue("5A bit0", serialOut, 0);
        idle(D);
        checkValue("5A bit1", serialOut, 1);
        idle(FrameClks - 2 * D);
        checkValue("tx_ready after 5A", bus.tx_ready, 1);

        // RX 0x3C
        errBase = errPulses;
        sendFrame(8'h3C, 1'b1);
        checkValue("rx_valid before stop sample", probeValid[1], 0);
        checkValue("rx_valid after stop sample", probeValid[2], 1);
        checkValue("rx 3C valid", bus.rx_valid, 1);
        checkValue("rx 3C byte", bus.rx_byte, 8'h3C);
        checkValue("rx 3C no err", errPulses - errBase, 0);
        popOne();
        checkValue("rx empty after pop", bus.rx_valid, 0);
        checkValue("rx_byte zero when empty", bus.rx_byte, 8'h00);

        // framing error then recovery
        sendFrame(8'h55, 1'b0);
        idle(20);
        checkValue("framing err pulse", errPulses - errBase, 1);
        checkValue("framing err no valid", bus.rx_valid, 0);
        sendFrame(8'h11, 1'b1);
        checkValue("rx 11 valid", bus.rx_valid, 1);
        checkValue("rx 11 byte", bus.rx_byte, 8'h11);
        checkValue("rx 11 no err", errPulses - errBase, 1);
        popOne();

        // CTS and overrun
        sendFrame(8'h01, 1'b1);
        checkValue("cts during first frame", probeCts[0], 1);
        idle(5);
        checkValue("cts with one entry", ctsOut, 1);
        sendFrame(8'h02, 1'b1);
        checkValue("cts at second frame start", probeCts[0], 0);
        idle(5);
        checkValue("cts buffer full", ctsOut, 0);
        checkValue("head still 01", bus.rx_byte, 8'h01);
        ovrBase = ovrPulses;
        sendFrame(8'h03, 1'b1);
        idle(5);
        checkValue("overrun pulse", ovrPulses - ovrBase, 1);
        checkValue("head after overrun", bus.rx_byte, 8'h01);
        popOne();
        checkValue("cts on pop cycle", ctsOut, 0);
        checkValue("head after pop", bus.rx_byte, 8'h02);
        tick();
        checkValue("cts after pop", ctsOut, 1);
        popOne();
        checkValue("buffer drained", bus.rx_valid, 0);

        // glitch rejected, RX still receives afterwards
        errBase  = errPulses;
        serialIn = 1'b0;
        idle(100);
        serialIn = 1'b1;
        idle(500);
        checkValue("glitch no valid", bus.rx_valid, 0);
        checkValue("glitch no err", errPulses - errBase, 0);
        sendFrame(8'h7E, 1'b1);
        checkValue("rx 7E after glitch", bus.rx_byte, 8'h7E);
        popOne();

        // reset in the middle of a TX frame
        bus.tx_byte  = 8'h00;
        bus.tx_valid = 1'b1;
        tick();
        bus.tx_valid = 1'b0;
        idle(1000);
        checkValue("tx low mid frame", serialOut, 0);
        nReset = 1'b0;
        #1;
        checkValue("serial_out on reset", serialOut, 1);
        checkValue("tx_ready on reset", bus.tx_ready, 0);
        checkValue("cts_out on reset", ctsOut, 1);
        tick();
        nReset = 1'b1;
        checkValue("tx_ready first cycle again", bus.tx_ready, 0);
        tick();
        checkValue("tx_ready after reset release", bus.tx_ready, 1);
        checkValue("line idle after reset", serialOut, 1);

        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
        $finish;
    end

endmodule
